mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and physical-memory buses
// served by mem_arbiter.
//   i_*    : I-cache line-fill request, address, returned line, completion
//   d_*    : D-cache fill/write-back request, address, write line, returned
//            line, completion
//   pmem_* : shared physical-memory command, address, write line, read line,
//            completion
// Modports:
//   slave  : the arbiter side
//   master : the environment side (caches plus memory)
interface mem_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between an I-cache and a
// D-cache. Ties are broken in favour of the requester not served last.
// The pmem command, address and write data come only from registers
// latched on the granting edge; completion strobes are qualified by state.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (I-cache, D-cache and pmem buses)
module mem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  // D wins when it is the only requester, or on a tie when I was served last.
  always_comb begin
    i_req   = bus.i_read;
    d_req   = bus.d_read | bus.d_write;
    grant_d = d_req & (~i_req | (last_grant == GRANT_I));
  end

  // read_q/write_q are both the latched operation and the pmem command, so
  // the command is registered and holds until completion. Completion always
  // returns to IDLE, guaranteeing an idle cycle between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= SERVE_D;
            addr_q  <= bus.d_address;
            wdata_q <= bus.d_wdata;
            // A simultaneous read and write is treated as a write-back.
            write_q <= bus.d_write;
            read_q  <= bus.d_read & ~bus.d_write;
          end else if (i_req) begin
            state   <= SERVE_I;
            addr_q  <= bus.i_address;
            wdata_q <= '0;
            read_q  <= 1'b1;
            write_q <= 1'b0;
          end
        end
        SERVE_I: begin
          if (bus.pmem_resp) begin
            state      <= IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            last_grant <= GRANT_I;
          end
        end
        SERVE_D: begin
          if (bus.pmem_resp) begin
            state      <= IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            last_grant <= GRANT_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pmem_read    = read_q;
    bus.pmem_write   = write_q;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_rdata      = bus.pmem_rdata;
    bus.d_rdata      = bus.pmem_rdata;
    bus.i_resp       = (state == SERVE_I) & bus.pmem_resp;
    bus.d_resp       = (state == SERVE_D) & bus.pmem_resp;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference model: one transaction owner (0 none, 1 I, 2 D) and the
  // command it was granted with; ties go to whoever was not served last.
  int              m_owner;
  bit              m_last_d;
  bit              m_rd, m_wr;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_last_d = 0; m_rd = 0; m_wr = 0;
    end else if (m_owner == 0) begin
      bit want_i, want_d;
      want_i = bus.i_read;
      want_d = bus.d_read || bus.d_write;
      if (want_d && (!want_i || !m_last_d)) begin
        m_owner = 2; m_addr = bus.d_address; m_wdata = bus.d_wdata;
        m_wr = bus.d_write; m_rd = !bus.d_write;
      end else if (want_i) begin
        m_owner = 1; m_addr = bus.i_address; m_rd = 1; m_wr = 0;
      end
    end else if (bus.pmem_resp) begin
      m_last_d = (m_owner == 2);
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  end

  typedef struct {
    logic ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [7:0] wb;
    logic presp;
    logic e_rd, e_wr, e_ir, e_dr;
    logic chk_a;
    logic [AW-1:0] e_a;
    logic chk_w;
  } vec_t;

  vec_t vecs[12];

  task automatic clear_inputs();
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    #1;
    chk("rst_pmem_read", LW'(bus.pmem_read), '0);
    chk("rst_pmem_write", LW'(bus.pmem_write), '0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [LW-1:0] a5, lw_rand;
    bit found, got_d;
    passed = 0; total = 0;
    rst_n = 1;
    clear_inputs();
    a5 = {32{8'hA5}};

    //            ir dr dw  ia       da     wb    rsp rd wr ir dr ca  e_a    cw
    vecs[0]  = '{1, 1, 0, 32'h100, 32'h200, 8'h00, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    vecs[1]  = '{1, 1, 0, 32'h100, 32'h200, 8'h00, 0, 1, 0, 0, 0, 1, 32'h200, 0};
    vecs[2]  = '{1, 1, 0, 32'h100, 32'h200, 8'h00, 1, 1, 0, 0, 1, 1, 32'h200, 0};
    vecs[3]  = '{1, 0, 0, 32'h100, 32'h200, 8'h00, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    vecs[4]  = '{1, 0, 0, 32'h100, 32'h200, 8'h00, 0, 1, 0, 0, 0, 1, 32'h100, 0};
    vecs[5]  = '{1, 0, 0, 32'h100, 32'h200, 8'h00, 1, 1, 0, 1, 0, 1, 32'h100, 0};
    vecs[6]  = '{0, 0, 0, 32'h100, 32'h200, 8'h00, 1, 0, 0, 0, 0, 0, 32'h0,   0};
    vecs[7]  = '{0, 1, 1, 32'h0,   32'h300, 8'h5A, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    vecs[8]  = '{0, 1, 1, 32'h0,   32'h400, 8'h5A, 0, 0, 1, 0, 0, 1, 32'h300, 1};
    vecs[9]  = '{0, 1, 1, 32'h0,   32'h400, 8'h5A, 1, 0, 1, 0, 1, 1, 32'h300, 1};
    vecs[10] = '{0, 0, 0, 32'h0,   32'h0,   8'h00, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    vecs[11] = '{0, 0, 0, 32'h0,   32'h0,   8'h00, 0, 0, 0, 0, 0, 0, 32'h0,   0};

    // Tie from reset, alternation, stray resp, read+write conflict, address hold
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.i_read = vecs[i].ir; bus.i_address = vecs[i].ia;
      bus.d_read = vecs[i].dr; bus.d_write = vecs[i].dw;
      bus.d_address = vecs[i].da; bus.d_wdata = {32{vecs[i].wb}};
      bus.pmem_resp = vecs[i].presp;
      lw_rand = {8{$urandom}};
      bus.pmem_rdata = lw_rand;
      #1;
      chk($sformatf("v%0d_pmem_read", i), LW'(bus.pmem_read), LW'(vecs[i].e_rd));
      chk($sformatf("v%0d_pmem_write", i), LW'(bus.pmem_write), LW'(vecs[i].e_wr));
      chk($sformatf("v%0d_i_resp", i), LW'(bus.i_resp), LW'(vecs[i].e_ir));
      chk($sformatf("v%0d_d_resp", i), LW'(bus.d_resp), LW'(vecs[i].e_dr));
      chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, lw_rand);
      if (vecs[i].chk_a)
        chk($sformatf("v%0d_pmem_address", i), LW'(bus.pmem_address), LW'(vecs[i].e_a));
      if (vecs[i].chk_w)
        chk($sformatf("v%0d_pmem_wdata", i), bus.pmem_wdata, {32{8'h5A}});
    end

    // I-only read with a 5-cycle memory latency
    do_reset();
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h0000_1000;
    #1 chk("ionly_idle", LW'(bus.pmem_read), '0);
    @(negedge clk);
    #1 chk("ionly_cmd", LW'(bus.pmem_read), LW'(1));
    chk("ionly_addr", LW'(bus.pmem_address), LW'(32'h1000));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("ionly_wait_resp", LW'(bus.i_resp), '0);
      chk("ionly_hold", LW'(bus.pmem_read), LW'(1));
    end
    @(negedge clk);
    bus.pmem_resp = 1; bus.pmem_rdata = a5;
    #1 chk("ionly_resp", LW'(bus.i_resp), LW'(1));
    chk("ionly_rdata", bus.i_rdata, a5);
    @(negedge clk);
    bus.pmem_resp = 0; bus.i_read = 0;
    #1 chk("ionly_resp_1cyc", LW'(bus.i_resp), '0);
    chk("ionly_back_idle", LW'(bus.pmem_read), '0);

    // Reset pulse during SERVE_I
    do_reset();
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h700;
    @(negedge clk);
    #1 chk("rstmid_cmd", LW'(bus.pmem_read), LW'(1));
    #2 rst_n = 0; bus.pmem_resp = 1;
    #1 chk("rstmid_async_read", LW'(bus.pmem_read), '0);
    chk("rstmid_no_resp", LW'(bus.i_resp), '0);
    @(negedge clk);
    rst_n = 1; bus.pmem_resp = 0;
    #1 chk("rstmid_idle", LW'(bus.pmem_read), '0);
    @(negedge clk);
    #1 chk("rstmid_regrant", LW'(bus.pmem_read), LW'(1));
    chk("rstmid_addr", LW'(bus.pmem_address), LW'(32'h700));
    @(negedge clk);
    bus.pmem_resp = 1;
    @(negedge clk);
    bus.pmem_resp = 0; bus.i_read = 0;

    // Back-to-back D writes with I waiting: grants must alternate D, I, D, ...
    do_reset();
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h800;
    bus.d_write = 1; bus.d_address = 32'h900; bus.d_wdata = {8{$urandom}};
    for (int k = 0; k < 6; k++) begin
      found = 0; got_d = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        bus.pmem_resp = 0;
        #1;
        if (bus.pmem_read || bus.pmem_write) begin
          found = 1; got_d = bus.pmem_write; bus.pmem_resp = 1;
          break;
        end
      end
      if (!found) begin
        total++;
        $display("FAIL alt_timeout: got no command, expected grant %0d", k);
      end else begin
        chk($sformatf("alt_grant%0d_is_d", k), LW'(got_d), LW'(k % 2 == 0));
        if (got_d) bus.d_address = bus.d_address + 32'h40;
        else bus.i_address = bus.i_address + 32'h40;
      end
    end
    @(negedge clk);
    clear_inputs();

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.i_read = ~bus.i_read;
      if ($urandom_range(0, 3) == 0) bus.d_read = ~bus.d_read;
      if ($urandom_range(0, 5) == 0) bus.d_write = ~bus.d_write;
      bus.i_address = $urandom;
      bus.d_address = $urandom;
      bus.d_wdata = {8{$urandom}};
      bus.pmem_resp = ($urandom_range(0, 2) == 0);
      bus.pmem_rdata = {8{$urandom}};
      #1;
      chk("rnd_pmem_read", LW'(bus.pmem_read), LW'(m_rd));
      chk("rnd_pmem_write", LW'(bus.pmem_write), LW'(m_wr));
      chk("rnd_i_resp", LW'(bus.i_resp), LW'(m_owner == 1 && bus.pmem_resp));
      chk("rnd_d_resp", LW'(bus.d_resp), LW'(m_owner == 2 && bus.pmem_resp));
      chk("rnd_i_rdata", bus.i_rdata, bus.pmem_rdata);
      if (m_owner != 0) chk("rnd_pmem_address", LW'(bus.pmem_address), LW'(m_addr));
      if (m_wr) chk("rnd_pmem_wdata", bus.pmem_wdata, m_wdata);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
